// File: rtl/data_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pipe
// Purpose  : Single-port word memory with a pipelined read path of latency
//            RD_LAT and a background zero-fill engine (IDLE/CLEAR FSM).
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_pipe #(
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RD_LAT = 2   // legal range 1..4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   input  logic          clear_start,
   output logic          clear_busy,
   output logic          clear_done
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t          state;
   logic [AW-1:0]   cnt;
   logic [DW-1:0]   mem [DEPTH];

   // Read pipeline: stage 0 captures the word in the accept cycle; the last
   // stage drives the response. Data is kept at zero in invalid stages so the
   // response data reads zero whenever no response is present.
   logic            pipe_vld  [RD_LAT];
   logic [DW-1:0]   pipe_data [RD_LAT];

   logic            accept;
   logic            rd_accept;
   logic            wr_accept;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;
   assign rd_accept = accept & ~req_write;
   assign wr_accept = accept &  req_write;

   // Clear FSM: walks the fill counter through every address, then pulses done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_start) begin
                  state      <= CLEAR;
                  clear_busy <= 1'b1;
                  cnt        <= '0;
               end
            end
            CLEAR: begin
               // Counter wraps naturally to 0 after the last address.
               cnt <= cnt + 1'b1;
               if (cnt == {AW{1'b1}}) begin
                  state      <= IDLE;
                  clear_busy <= 1'b0;
                  clear_done <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               clear_busy <= 1'b0;
            end
         endcase
      end
   end

   // Memory array: fill writes own the port in CLEAR, requests only in IDLE.
   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr_accept) begin
         mem[req_addr] <= req_wdata;
      end
   end

   // Read pipeline shift: sample in the accept cycle, advance one stage per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_vld[i]  <= 1'b0;
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_vld[0]  <= rd_accept;
         pipe_data[0] <= rd_accept ? mem[req_addr] : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign rsp_valid = pipe_vld[RD_LAT-1];
   assign rsp_data  = pipe_data[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_pipe
// Purpose  : Directed self-checking bench; three instances (RD_LAT 1, 2, 4,
//            AW 4) share one stimulus stream and are checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_pipe;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int NI   = 3;
   localparam int MAXC = 1024;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          clear_start;

   logic          req_ready  [NI];
   logic          rsp_valid  [NI];
   logic [DW-1:0] rsp_data   [NI];
   logic          clear_busy [NI];
   logic          clear_done [NI];

   int lat [NI] = '{1, 2, 4};

   // Expected response per instance per cycle (cycle = rising edges seen).
   logic          exp_v [NI][MAXC];
   logic [DW-1:0] exp_d [NI][MAXC];

   int cyc;
   int n_checks;
   int n_pass;

   data_mem_pipe #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .clear_start(clear_start),
      .clear_busy(clear_busy[0]), .clear_done(clear_done[0]));

   data_mem_pipe #(.AW(AW), .DW(DW), .RD_LAT(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .clear_start(clear_start),
      .clear_busy(clear_busy[1]), .clear_done(clear_done[1]));

   data_mem_pipe #(.AW(AW), .DW(DW), .RD_LAT(4)) u_lat4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[2]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .clear_start(clear_start),
      .clear_busy(clear_busy[2]), .clear_done(clear_done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One clock: inputs are taken at the rising edge, outputs checked at the falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("rsp_valid lat%0d", lat[k]), 32'(rsp_valid[k]), 32'(exp_v[k][cyc]));
         check($sformatf("rsp_data lat%0d", lat[k]), 32'(rsp_data[k]), 32'(exp_d[k][cyc]));
      end
   endtask

   task automatic check_ctrl(input string tag, input logic busy, input logic done, input logic ready);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s clear_busy lat%0d", tag, lat[k]), 32'(clear_busy[k]), 32'(busy));
         check($sformatf("%s clear_done lat%0d", tag, lat[k]), 32'(clear_done[k]), 32'(done));
         check($sformatf("%s req_ready lat%0d", tag, lat[k]), 32'(req_ready[k]), 32'(ready));
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
      tick();
      req_valid = 1'b0; req_write = 1'b0;
   endtask

   // Read whose response is expected lat cycles after the accept edge.
   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
      for (int k = 0; k < NI; k++) begin
         exp_v[k][cyc + lat[k]] = 1'b1;
         exp_d[k][cyc + lat[k]] = d;
      end
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      #1;
      check_ctrl("in reset", 1'b0, 1'b0, 1'b1);
      idle(n);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < NI; k++)
         for (int c = 0; c < MAXC; c++) begin
            exp_v[k][c] = 1'b0;
            exp_d[k][c] = '0;
         end
      cyc = 0; n_checks = 0; n_pass = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; clear_start = 1'b0;

      // Reset state, then accept on the very first edge after release.
      idle(2);
      check_ctrl("reset", 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;

      // Write then read-after-write on the next cycle.
      wr(4'd3, 8'hA5);
      rd(4'd3, 8'hA5);
      idle(6);

      // Back-to-back reads give back-to-back responses in order.
      for (int i = 0; i < 4; i++) wr(4'(i), 8'(8'h10 + i));
      for (int i = 0; i < 4; i++) rd(4'(i), 8'(8'h10 + i));
      idle(6);

      // In-flight read at clear entry, then clear_start with a simultaneous write.
      rd(4'd2, 8'h12);
      clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b1;
      req_addr = 4'd5; req_wdata = 8'h77;
      tick();
      clear_start = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check_ctrl($sformatf("fill cycle %0d", i), 1'b1, 1'b0, 1'b0);
         if (i == 4) begin
            // Second start and a read are both ignored while filling.
            clear_start = 1'b1; req_valid = 1'b1; req_addr = 4'd3;
         end
         tick();
         clear_start = 1'b0; req_valid = 1'b0;
      end
      check_ctrl("fill end", 1'b0, 1'b1, 1'b1);
      tick();
      check_ctrl("after done", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);
      idle(6);

      // Known pattern for the reset scenarios.
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h80 + i));

      // Read accepted, then reset before any response: no response at all.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd9;
      @(posedge clk);
      cyc++;
      #2;
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++)
         check($sformatf("killed read lat%0d", lat[k]), 32'(rsp_valid[k]), 32'd0);
      do_reset(2);
      idle(5);
      rd(4'd9, 8'h89);
      rd(4'd14, 8'h8E);
      idle(5);

      // Reset after eight fill cycles: lower half cleared, upper half intact.
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      idle(8);
      check_ctrl("mid fill", 1'b1, 1'b0, 1'b0);
      do_reset(2);
      for (int i = 0; i < 16; i++) rd(4'(i), (i < 8) ? 8'h00 : 8'(8'h80 + i));
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter AW, default 8, address width; memory depth is 2**AW words.
REQ-002 SHALL have parameter DW, default 8, data word width.
REQ-003 SHALL have parameter RD_LAT, default 2, read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  AW  word address.
REQ-010 SHALL have port req_wdata  input  DW  write data.
REQ-011 SHALL have port rsp_valid  output  1  read data valid, one-cycle pulse per accepted read.
REQ-012 SHALL have port rsp_data  output  DW  read data.
REQ-013 SHALL have port clear_start  input  1  one-cycle pulse; starts zero-fill of whole memory.
REQ-014 SHALL have port clear_busy  output  1  zero-fill in progress.
REQ-015 SHALL have port clear_done  output  1  one-cycle pulse when zero-fill completes.

Function
REQ-016 SHALL accept a request in a cycle where req_valid and req_ready are both 1 (accept cycle).
REQ-017 SHALL perform an accepted write at the end of the accept cycle; no response for writes.
REQ-018 SHALL sample an accepted read's memory word in the accept cycle and assert rsp_valid with that word exactly RD_LAT cycles after the accept cycle.
REQ-019 SHALL return the new data for a read accepted the cycle after a write to the same address.
REQ-020 SHALL sustain one accepted request per cycle; back-to-back reads SHALL produce back-to-back responses in acceptance order.
REQ-021 SHALL drive rsp_data to 0 whenever rsp_valid is 0 (no high-impedance output).
REQ-022 SHALL implement FSM states IDLE and CLEAR; req_ready = 1 in IDLE, 0 in CLEAR.
REQ-023 SHALL go IDLE -> CLEAR on clear_start in IDLE; a request accepted in that same cycle SHALL be performed before the fill starts.
REQ-024 SHALL in CLEAR write 0 to address counter value each cycle, counter from 0 to 2**AW-1, one address per cycle, so fill lasts exactly 2**AW cycles.
REQ-025 SHALL go CLEAR -> IDLE after writing address 2**AW-1, pulse clear_done in the first IDLE cycle, and wrap counter to 0.
REQ-026 SHALL ignore clear_start while in CLEAR.
REQ-027 SHALL let reads in flight at CLEAR entry complete on schedule with data sampled at their accept cycle.
REQ-028 SHALL hold clear_busy = 1 exactly while in CLEAR.

Reset
REQ-029 SHALL on rst_n low immediately force: state IDLE, counter 0, rsp_valid 0, rsp_data 0, clear_busy 0, clear_done 0, all read-pipeline valid bits 0.
REQ-030 SHALL not reset memory contents; reset mid-CLEAR leaves memory partially cleared and discards in-flight reads without responses.
REQ-031 SHALL accept requests from the first rising edge after rst_n deasserts.

Verification
REQ-032 Write 0xA5 to addr 3, next cycle read addr 3, RD_LAT=2 -> rsp_valid pulse 2 cycles after read accept, rsp_data 0xA5; rsp_data 0 otherwise.
REQ-033 Reads of addr 0,1,2,3 on 4 consecutive cycles after writing 0x10..0x13 -> 4 consecutive rsp_valid cycles with 0x10,0x11,0x12,0x13.
REQ-034 AW=4: clear_start in IDLE -> req_ready 0 and clear_busy 1 for 16 cycles, clear_done pulse once, all 16 words then read 0.
REQ-035 clear_start with a simultaneous write of 0x77 to addr 5 -> write accepted, fill proceeds, addr 5 reads 0 afterwards; second clear_start during CLEAR has no effect (still 16 cycles).
REQ-036 Read accepted, rst_n pulsed low before its response -> no rsp_valid; after reset memory retains prior writes; reset at fill cycle 8 -> addrs 0..7 read 0, addrs 8..15 keep old data.
REQ-037 Repeat REQ-032 and REQ-033 with RD_LAT=1 and RD_LAT=4 -> response timing scales to 1 and 4 cycles.
